// File: rtl/dtpu_input_fifo.sv
// dtpu_input_fifo: AXI-stream slave to first-word-fall-through buffer feeding the
// dtpu_core input-FIFO read port. Occupancy is derived from a pair of wrapping
// pointers that are one bit wider than the address. The head word is held in a register.
module dtpu_input_fifo #(
    parameter int DATA_WIDTH_FIFO_IN = 64,
    parameter int DEPTH              = 16,
    parameter int AFULL_THRESH       = 12
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [DATA_WIDTH_FIFO_IN-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic                          s_axis_afull,
    input  logic                          flush,
    output logic                          infifo_is_empty,
    output logic [DATA_WIDTH_FIFO_IN-1:0] infifo_dout,
    output logic                          infifo_last,
    input  logic                          infifo_read,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_THRESH);

    logic [DATA_WIDTH_FIFO_IN:0]   mem [DEPTH];

    logic [AW:0]                   wr_ptr_q, wr_ptr_d;
    logic [AW:0]                   rd_ptr_q, rd_ptr_d;
    logic [AW:0]                   level_q, level_d;
    logic                          tready_q, tready_d;
    logic                          afull_q, afull_d;
    logic                          empty_q, empty_d;
    logic                          underflow_q, underflow_d;
    logic [DATA_WIDTH_FIFO_IN-1:0] dout_q, dout_d;
    logic                          last_q, last_d;

    logic                          push_w;
    logic                          pop_w;
    logic                          full_d;
    logic [DATA_WIDTH_FIFO_IN:0]   head_w;

    // Handshakes qualify on registered status; flush kills both directions.
    assign push_w = s_axis_tvalid & tready_q & ~flush;
    assign pop_w  = infifo_read & ~empty_q & ~flush;

    // Next-state pointers, status and head word.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        underflow_d = underflow_q;
        dout_d      = dout_q;
        last_d      = last_q;
        head_w      = '0;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            underflow_d = 1'b0;
        end else begin
            if (push_w) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (infifo_read && empty_q) underflow_d = 1'b1;
        end

        level_d = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        tready_d = ~full_d;
        afull_d  = (level_d >= AFULL_L);

        // The new head is the word being written this edge when the read pointer
        // lands on the write slot; otherwise the head is already in the RAM.
        if (!flush && !empty_d) begin
            if (push_w && (rd_ptr_d == wr_ptr_q)) begin
                head_w = {s_axis_tlast, s_axis_tdata};
            end else begin
                head_w = mem[rd_ptr_d[AW-1:0]];
            end
            dout_d = head_w[DATA_WIDTH_FIFO_IN-1:0];
            last_d = head_w[DATA_WIDTH_FIFO_IN];
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_w) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tready_q    <= 1'b0;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
            dout_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tready_q    <= tready_d;
            afull_q     <= afull_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
            last_q      <= last_d;
        end
    end

    assign s_axis_tready   = tready_q;
    assign s_axis_afull    = afull_q;
    assign infifo_is_empty = empty_q;
    assign infifo_dout     = dout_q;
    assign infifo_last     = last_q;
    assign level           = level_q;
    assign underflow       = underflow_q;

endmodule
